// File: rtl/mage_cfg_loader_pkg.sv
// rtl/mage_cfg_loader_pkg.sv - config loader error codes, FSM states, register file map
package mage_cfg_loader_pkg;

  typedef enum logic [1:0] {
    CFG_ERR_NONE     = 2'd0,
    CFG_ERR_BUS      = 2'd1,
    CFG_ERR_MISMATCH = 2'd2,
    CFG_ERR_ABORT    = 2'd3
  } cfg_err_e;

  typedef enum logic [2:0] {
    CFG_IDLE,
    CFG_FETCH,
    CFG_WRITE,
    CFG_READ,
    CFG_CHECK,
    CFG_FINISH
  } cfg_state_e;

  // Mage register file regions that software uses to build base_addr_i
  localparam logic [31:0] MAGE_PE_CFG_BASE    = 32'h0000_0000;
  localparam logic [31:0] MAGE_PEA_CONST_BASE = 32'h0000_1000;
  localparam logic [31:0] MAGE_ACC_BASE       = 32'h0000_2000;
  localparam logic [31:0] MAGE_XBAR_SEL_BASE  = 32'h0000_3000;

  function automatic logic [31:0] cfg_addr_step(input logic [31:0] addr,
                                                input logic [31:0] stride);
    return addr + stride;
  endfunction

endpackage

// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - register bus request/response types
package reg_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

// File: rtl/mage_cfg_loader.sv
// rtl/mage_cfg_loader.sv - streams a configuration image into the Mage register file
module mage_cfg_loader
  import reg_pkg::*;
  import mage_cfg_loader_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int ADDR_STRIDE = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             verify_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] num_words_i,
  input  logic [31:0]      cfg_data_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output reg_req_t         reg_req_o,
  input  reg_rsp_t         reg_rsp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [31:0]      err_addr_o,
  output logic [CNT_W-1:0] words_done_o
);

  cfg_state_e       state;
  logic [31:0]      cur_addr;
  logic [31:0]      word_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] num_words_q;
  logic             verify_q;
  logic             abort_q;

  logic [CNT_W-1:0] words_next;
  logic [31:0]      addr_next;
  logic             last_word;
  logic             abort_seen;
  logic             xfer_done;

  always_comb begin
    words_next = words_done_o + CNT_W'(1);
    addr_next  = cfg_addr_step(cur_addr, 32'(ADDR_STRIDE));
    last_word  = (words_next == num_words_q);
    abort_seen = abort_q | abort_i;
    xfer_done  = reg_req_o.valid & reg_rsp_i.ready;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= CFG_IDLE;
      cur_addr     <= '0;
      word_q       <= '0;
      rdata_q      <= '0;
      num_words_q  <= '0;
      verify_q     <= 1'b0;
      abort_q      <= 1'b0;
      cfg_ready_o  <= 1'b0;
      reg_req_o    <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      err_code_o   <= CFG_ERR_NONE;
      err_addr_o   <= '0;
      words_done_o <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        CFG_IDLE: begin
          if (start_i) begin
            cur_addr     <= base_addr_i;
            num_words_q  <= num_words_i;
            verify_q     <= verify_i;
            abort_q      <= 1'b0;
            err_o        <= 1'b0;
            err_code_o   <= CFG_ERR_NONE;
            err_addr_o   <= '0;
            words_done_o <= '0;
            busy_o       <= 1'b1;
            if (num_words_i == '0) begin
              state <= CFG_FINISH;
            end else begin
              state       <= CFG_FETCH;
              cfg_ready_o <= 1'b1;
            end
          end
        end
        CFG_FETCH: begin
          if (abort_i) begin
            cfg_ready_o <= 1'b0;
            err_o       <= 1'b1;
            err_code_o  <= CFG_ERR_ABORT;
            err_addr_o  <= cur_addr;
            state       <= CFG_FINISH;
          end else if (cfg_valid_i) begin
            cfg_ready_o <= 1'b0;
            word_q      <= cfg_data_i;
            reg_req_o   <= '{addr: cur_addr, write: 1'b1, wdata: cfg_data_i,
                             wstrb: 4'hF, valid: 1'b1};
            state       <= CFG_WRITE;
          end
        end
        CFG_WRITE: begin
          if (abort_i) abort_q <= 1'b1;
          if (xfer_done) begin
            if (reg_rsp_i.error) begin
              reg_req_o  <= '0;
              err_o      <= 1'b1;
              err_code_o <= CFG_ERR_BUS;
              err_addr_o <= cur_addr;
              state      <= CFG_FINISH;
            end else if (verify_q && !abort_seen) begin
              // keep valid asserted straight into the readback of the same address
              reg_req_o.write <= 1'b0;
              reg_req_o.wstrb <= '0;
              reg_req_o.wdata <= '0;
              state           <= CFG_READ;
            end else begin
              reg_req_o <= '0;
              if (!verify_q) begin
                words_done_o <= words_next;
                cur_addr     <= addr_next;
              end
              if (abort_seen) begin
                err_o      <= 1'b1;
                err_code_o <= CFG_ERR_ABORT;
                err_addr_o <= cur_addr;
                state      <= CFG_FINISH;
              end else if (last_word) begin
                state <= CFG_FINISH;
              end else begin
                state       <= CFG_FETCH;
                cfg_ready_o <= 1'b1;
              end
            end
          end
        end
        CFG_READ: begin
          if (abort_i) abort_q <= 1'b1;
          if (xfer_done) begin
            reg_req_o <= '0;
            if (reg_rsp_i.error) begin
              err_o      <= 1'b1;
              err_code_o <= CFG_ERR_BUS;
              err_addr_o <= cur_addr;
              state      <= CFG_FINISH;
            end else if (abort_seen) begin
              err_o      <= 1'b1;
              err_code_o <= CFG_ERR_ABORT;
              err_addr_o <= cur_addr;
              state      <= CFG_FINISH;
            end else begin
              rdata_q <= reg_rsp_i.rdata;
              state   <= CFG_CHECK;
            end
          end
        end
        CFG_CHECK: begin
          if (rdata_q != word_q) begin
            err_o      <= 1'b1;
            err_code_o <= CFG_ERR_MISMATCH;
            err_addr_o <= cur_addr;
            state      <= CFG_FINISH;
          end else if (abort_i) begin
            err_o      <= 1'b1;
            err_code_o <= CFG_ERR_ABORT;
            err_addr_o <= cur_addr;
            state      <= CFG_FINISH;
          end else begin
            words_done_o <= words_next;
            cur_addr     <= addr_next;
            if (last_word) begin
              state <= CFG_FINISH;
            end else begin
              state       <= CFG_FETCH;
              cfg_ready_o <= 1'b1;
            end
          end
        end
        CFG_FINISH: begin
          done_o  <= 1'b1;
          busy_o  <= 1'b0;
          abort_q <= 1'b0;
          state   <= CFG_IDLE;
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

endmodule
